// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 data-memory arbiter: bus widths,
// requester IDs and the arbiter FSM state encoding.
package z16_pkg;

    localparam int Z16_ADDR_W = 16;
    localparam int Z16_DATA_W = 16;

    // Requester IDs; also the bit position of each port in a req/gnt pair
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCK_B = 1'b1
    } arb_state_t;

endpackage

// File: rtl/z16_rr_arb2.sv
// Two-way round-robin picker. A lone request is granted directly; on a
// tie the port that did not win last time gets the grant.
module z16_rr_arb2
    import z16_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);

    // Tie-break against the previous winner
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (i_last_gnt == REQ_B) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Two-port arbiter in front of the single-port Z16 data memory.
// Port A (CPU LSU) and port B (DMA/loader) share one access per cycle with
// round-robin fairness; B can hold the memory for bursts of up to LOCK_MAX
// beats. Read data is registered and returned one cycle after the grant.
// Optional feature: define Z16_DMEM_ARB_MISALIGN_ERR_EN to flag odd byte
// addresses as errors (write suppressed, read data zero, err pulse).
module z16_dmem_arbiter
    import z16_pkg::*;
#(
    parameter int ADDR_W   = Z16_ADDR_W,
    parameter int DATA_W   = Z16_DATA_W,
    parameter int LOCK_MAX = 8
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic              o_a_err,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    input  logic              i_b_lock,
    output logic              o_b_gnt,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic              o_b_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int               CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       r_state;
    logic             r_last_gnt;
    logic [CNT_W-1:0] r_lock_cnt;

    logic              r_a_rvalid, r_b_rvalid;
    logic              r_a_err,    r_b_err;
    logic [DATA_W-1:0] r_a_rdata,  r_b_rdata;

    logic [1:0] w_rr_gnt;
    logic       w_a_gnt, w_b_gnt;
    logic       w_a_mis, w_b_mis;

`ifdef Z16_DMEM_ARB_MISALIGN_ERR_EN
    assign w_a_mis = i_a_addr[0];
    assign w_b_mis = i_b_addr[0];
`else
    // Odd byte addresses just land on the containing word
    assign w_a_mis = 1'b0;
    assign w_b_mis = 1'b0;
`endif

    z16_rr_arb2 u_rr (
        .i_req      ({i_b_req, i_a_req}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_rr_gnt)
    );

    // Grant: round-robin when idle, B only while locked; nothing in reset
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (i_rst_n) begin
            if (r_state == ST_LOCK_B) begin
                w_b_gnt = i_b_req;
            end else begin
                w_a_gnt = w_rr_gnt[REQ_A];
                w_b_gnt = w_rr_gnt[REQ_B];
            end
        end
    end

    assign o_a_gnt     = w_a_gnt;
    assign o_b_gnt     = w_b_gnt;
    assign o_mem_addr  = w_b_gnt ? i_b_addr  : i_a_addr;
    assign o_mem_wdata = w_b_gnt ? i_b_wdata : i_a_wdata;
    assign o_mem_we    = (w_a_gnt & i_a_we & ~w_a_mis) |
                         (w_b_gnt & i_b_we & ~w_b_mis);

    // Lock FSM and fairness history. The beat that reaches LOCK_MAX drops
    // straight back to IDLE with last_gnt=B, so a waiting A wins next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= REQ_B;
            r_lock_cnt <= '0;
        end else begin
            if (w_a_gnt) r_last_gnt <= REQ_A;
            if (w_b_gnt) r_last_gnt <= REQ_B;
            case (r_state)
                ST_IDLE: begin
                    if (w_b_gnt && i_b_lock && (LOCK_MAX > 1)) begin
                        r_state    <= ST_LOCK_B;
                        r_lock_cnt <= CNT_W'(1);
                    end
                end
                ST_LOCK_B: begin
                    if (!i_b_req || !i_b_lock || (r_lock_cnt == LOCK_LAST)) begin
                        r_state    <= ST_IDLE;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

    // Port A response: capture read data at the granting edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_rvalid <= 1'b0;
            r_a_err    <= 1'b0;
            r_a_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~i_a_we;
            r_a_err    <= w_a_gnt & w_a_mis;
            if (w_a_gnt && !i_a_we) r_a_rdata <= w_a_mis ? '0 : i_mem_rdata;
        end
    end

    // Port B response: capture read data at the granting edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_b_rvalid <= 1'b0;
            r_b_err    <= 1'b0;
            r_b_rdata  <= '0;
        end else begin
            r_b_rvalid <= w_b_gnt & ~i_b_we;
            r_b_err    <= w_b_gnt & w_b_mis;
            if (w_b_gnt && !i_b_we) r_b_rdata <= w_b_mis ? '0 : i_mem_rdata;
        end
    end

    assign o_a_rvalid = r_a_rvalid;
    assign o_a_rdata  = r_a_rdata;
    assign o_a_err    = r_a_err;
    assign o_b_rvalid = r_b_rvalid;
    assign o_b_rdata  = r_b_rdata;
    assign o_b_err    = r_b_err;

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Bench for z16_dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model (grant rule, lock beats,
// word-addressed reference memory, one-cycle response).
module tb_z16_dmem_arbiter;

    localparam int LOCK_MAX = 8;
`ifdef Z16_DMEM_ARB_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0, b_lock = 0;
    logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_we;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata), .o_a_err(a_err),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .i_b_lock(b_lock),
        .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata), .o_b_err(b_err),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: 1024 words, combinational read
    logic        mem_clr = 1'b1;
    logic [15:0] mem [1024];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[10:1]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[10:1]];

    // Reference model state
    logic [15:0] ref_mem [1024];
    bit          m_last_b;
    int          m_beats;
    logic        x_a_rv, x_a_err, x_b_rv, x_b_err;
    logic [15:0] x_a_rd, x_b_rd;
    logic        rec_a, rec_b;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_beats  = 0;
        x_a_rv = 0; x_a_err = 0; x_a_rd = '0;
        x_b_rv = 0; x_b_err = 0; x_b_rd = '0;
    endtask

    // One cycle: drive at negedge, check grant side, clock, check responses
    task automatic step(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                        input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                        input logic bl);
        logic ea, eb, ewe, amis, bmis;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
        #1;
        if (m_beats > 0) begin
            ea = 1'b0; eb = br;
        end else if (ar && br) begin
            ea = m_last_b; eb = !m_last_b;
        end else begin
            ea = ar; eb = br;
        end
        amis = MIS_EN && aa[0];
        bmis = MIS_EN && ba[0];
        ewe  = (ea && aw && !amis) || (eb && bw && !bmis);
        chk("a_gnt", a_gnt, ea);
        chk("b_gnt", b_gnt, eb);
        chk("mem_we", mem_we, ewe);
        rec_a = a_gnt;
        rec_b = b_gnt;
        @(posedge clk);
        x_a_rv = ea && !aw;  x_a_err = ea && amis;
        x_b_rv = eb && !bw;  x_b_err = eb && bmis;
        if (ea && !aw) x_a_rd = amis ? 16'h0 : ref_mem[aa[10:1]];
        if (eb && !bw) x_b_rd = bmis ? 16'h0 : ref_mem[ba[10:1]];
        if (ea && aw && !amis) ref_mem[aa[10:1]] = ad;
        if (eb && bw && !bmis) ref_mem[ba[10:1]] = bd;
        if (ea) m_last_b = 1'b0;
        if (eb) begin
            m_last_b = 1'b1;
            if (bl) begin
                m_beats = m_beats + 1;
                if (m_beats >= LOCK_MAX) m_beats = 0;
            end else begin
                m_beats = 0;
            end
        end else begin
            m_beats = 0;
        end
        #1;
        chk("a_rvalid", a_rvalid, x_a_rv);
        chk("a_rdata", a_rdata, x_a_rd);
        chk("a_err", a_err, x_a_err);
        chk("b_rvalid", b_rvalid, x_b_rv);
        chk("b_rdata", b_rdata, x_b_rd);
        chk("b_err", b_err, x_b_err);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] old16;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        model_reset();

        // 1: reset held with both requesting
        a_req = 1; b_req = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_errs", {a_err, b_err}, 0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        step(1, 0, 16'h0040, 0, 1, 0, 16'h0042, 0, 0);
        chk("t1_first_a", {rec_b, rec_a}, 2'b01);

        // 2: A store then B load, same address
        step(1, 1, 16'h0010, 16'h1234, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 16'h0010, 0, 0);
        chk("t2_b_rvalid", b_rvalid, 1);
        chk("t2_b_rdata", b_rdata, 16'h1234);
        chk("t2_a_rvalid", a_rvalid, 0);

        // 3: continuous contention alternates, A first (B won last)
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 16'h0010, 0, 1, 0, 16'(2 * i), 0, 0);
            chk("t3_alt_a", rec_a, (i % 2) == 0);
        end

        // 4: B locked burst against a waiting A
        step(1, 0, 16'h0004, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 16'h0006, 0, 1, 1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i), 1);
            chk("t4_a", rec_a, i == 8);
            chk("t4_b", rec_b, i != 8);
        end
        step(1, 0, 16'h0006, 0, 0, 0, 0, 0, 0);  // B drops req: lock released
        step(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0);
        chk("t4_burst_data", a_rdata, 16'hA000);

        // 5: address wrap and reset during a pending read
        step(1, 1, 16'h0802, 16'hBEEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 16'h0002, 0, 0);
        chk("t5_wrap", b_rdata, 16'hBEEF);
        a_req = 1; a_we = 0; a_addr = 16'h0002;
        b_req = 1; b_we = 1; b_addr = 16'h0002; b_wdata = 16'hDEAD; b_lock = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", {a_gnt, b_gnt}, 0);
        chk("t5_rst_we", mem_we, 0);
        @(posedge clk); #1;
        chk("t5_rst_rvalid", {a_rvalid, b_rvalid}, 0);
        chk("t5_rst_rdata", b_rdata, 0);
        model_reset();
        @(negedge clk);
        a_req = 0; b_req = 0;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 0, 16'h0002, 0, 0);
        chk("t5_no_write", b_rdata, 16'hBEEF);

        // 6: odd-address store
        old16 = ref_mem[16];
        step(1, 1, 16'h0021, 16'h5555, 0, 0, 0, 0, 0);
        chk("t6_gnt", rec_a, 1);
        chk("t6_err", a_err, MIS_EN);
        chk("t6_word", mem[16], MIS_EN ? old16 : 16'h5555);

        // Random traffic over a small address window
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ra, rb;
            ra = {5'($urandom), 6'd0, 4'($urandom_range(0, 7)), 1'($urandom)};
            rb = {5'($urandom), 6'd0, 4'($urandom_range(0, 7)), 1'($urandom)};
            step(1'($urandom), 1'($urandom), ra, 16'($urandom),
                 1'($urandom), 1'($urandom), rb, 16'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 8; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
